// File: rtl/spi_readback_tx_pkg.sv
// spi_readback_tx_pkg
// Shared constants for the SPI status-readback transmit path: word width,
// the read command opcode, the register index map and the default
// identification word returned at index 0x07.
package spi_readback_tx_pkg;

    localparam int          SPI_WIDTH       = 16;
    localparam logic [7:0]  CMD_READ        = 8'hC0;

    localparam logic [7:0]  ADDR_MODE_LO    = 8'h00;
    localparam logic [7:0]  ADDR_MODE_HI    = 8'h01;
    localparam logic [7:0]  ADDR_SUB_CONTR  = 8'h02;
    localparam logic [7:0]  ADDR_MULT_CONTR = 8'h03;
    localparam logic [7:0]  ADDR_BEATEN_PIX = 8'h04;
    localparam logic [7:0]  ADDR_CNT_LO     = 8'h05;
    localparam logic [7:0]  ADDR_CNT_HI     = 8'h06;
    localparam logic [7:0]  ADDR_ID         = 8'h07;

    localparam logic [15:0] DEFAULT_ID_WORD = 16'hA55A;

endpackage

// File: rtl/spi_readback_tx_sync_edge.sv
// spi_sync_edge
// Multi-flop synchroniser for an asynchronous pin, followed by a registered
// edge detector. Pin edge to rise/fall pulse latency is STAGES+1 clocks.
//   clk_i   : system clock
//   srst_i  : synchronous active-high reset
//   async_i : asynchronous input pin
//   rise_o  : one-clock pulse on a detected 0->1 transition
//   fall_o  : one-clock pulse on a detected 1->0 transition
// INIT is the idle level of the pin, so leaving reset does not fake an edge.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i) begin
                    if (srst_i) sync_q[gi] <= INIT;
                    else        sync_q[gi] <= async_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk_i) begin
                    if (srst_i) sync_q[gi] <= INIT;
                    else        sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            prev_q <= INIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_readback_tx.sv
// spi_readback_tx
// SPI-slave transmit path for status readback. A one-clock RD_REQ snapshots
// one 16-bit status word selected by RD_ADDR; the word is shifted out
// MSB-first on SPI_MISO during the next chip-select frame (SPI mode 0, the
// master samples on SCK rise, the slave shifts on SCK fall).
//   CLK, RESET        : system clock, synchronous active-high reset
//   SPI_SCK, SPI_CS_N : asynchronous SPI pins, oversampled on CLK
//   SPI_MISO          : serial data to master
//   RD_REQ, RD_ADDR   : read strobe and register index
//   MODE_FPGA .. ALL_CNT : status sources for the snapshot
//   TX_BUSY           : word armed or being shifted
//   TX_DONE/TX_ABORT/TX_OVERRUN : one-clock event pulses
// All outputs are registered.
module spi_readback_tx
    import spi_readback_tx_pkg::*;
#(
    parameter int              SPI_W       = SPI_WIDTH,
    parameter int              SYNC_STAGES = 2,
    parameter logic [SPI_W-1:0] ID_WORD    = DEFAULT_ID_WORD
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SPI_SCK,
    input  logic        SPI_CS_N,
    output logic        SPI_MISO,
    input  logic        RD_REQ,
    input  logic [7:0]  RD_ADDR,
    input  logic [31:0] MODE_FPGA,
    input  logic [13:0] SUB_CONTRAST,
    input  logic [4:0]  MULT_CONTRAST,
    input  logic [13:0] BEATEN_PIX_LEVEL,
    input  logic [19:0] ALL_CNT,
    output logic        TX_BUSY,
    output logic        TX_DONE,
    output logic        TX_ABORT,
    output logic        TX_OVERRUN
);

    localparam int CNT_W = $clog2(SPI_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SPI_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic               miso_q, busy_q, done_q, abort_q, overrun_q;
    logic               abort_d, overrun_d;
    logic [SPI_W-1:0]   snap_word;
    logic               sck_rise, sck_fall;
    logic               cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
        .clk_i   (CLK),
        .srst_i  (RESET),
        .async_i (SPI_SCK),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
        .clk_i   (CLK),
        .srst_i  (RESET),
        .async_i (SPI_CS_N),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // Address mux: the word is captured in the same edge that samples RD_REQ.
    always_comb begin
        snap_word = '0;
        case (RD_ADDR)
            ADDR_MODE_LO:    snap_word = SPI_W'(MODE_FPGA[15:0]);
            ADDR_MODE_HI:    snap_word = SPI_W'(MODE_FPGA[31:16]);
            ADDR_SUB_CONTR:  snap_word = SPI_W'(SUB_CONTRAST);
            ADDR_MULT_CONTR: snap_word = SPI_W'(MULT_CONTRAST);
            ADDR_BEATEN_PIX: snap_word = SPI_W'(BEATEN_PIX_LEVEL);
            ADDR_CNT_LO:     snap_word = SPI_W'(ALL_CNT[15:0]);
            ADDR_CNT_HI:     snap_word = SPI_W'(ALL_CNT[19:16]);
            ADDR_ID:         snap_word = ID_WORD;
            default:         snap_word = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        abort_d   = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A frame that starts without an armed word is ignored.
                if (RD_REQ) begin
                    shreg_d  = snap_word;
                    bitcnt_d = '0;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Newest request replaces the armed word; not an overrun.
                if (RD_REQ) begin
                    shreg_d  = snap_word;
                    bitcnt_d = '0;
                end
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (RD_REQ) begin
                    overrun_d = 1'b1;
                end
                // The 16th fall is checked first so a simultaneous CS_N
                // rise still completes the word rather than aborting it.
                if (sck_fall) begin
                    shreg_d  = {shreg_q[SPI_W-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == CNT_W'(SPI_W - 1)) begin
                        state_d = ST_DONE;
                    end else if (cs_rise) begin
                        abort_d  = 1'b1;
                        shreg_d  = '0;
                        bitcnt_d = '0;
                        state_d  = ST_IDLE;
                    end
                end else if (cs_rise) begin
                    abort_d  = 1'b1;
                    shreg_d  = '0;
                    bitcnt_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                bitcnt_d = '0;
                if (RD_REQ) begin
                    shreg_d = snap_word;
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                shreg_d  = '0;
                bitcnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe without a combinational path to the pins.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            miso_q    <= ((state_d == ST_ARMED) || (state_d == ST_SHIFT))
                         ? shreg_d[SPI_W-1] : 1'b0;
            busy_q    <= (state_d == ST_ARMED) || (state_d == ST_SHIFT);
            done_q    <= (state_d == ST_DONE);
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
        end
    end

    assign SPI_MISO   = miso_q;
    assign TX_BUSY    = busy_q;
    assign TX_DONE    = done_q;
    assign TX_ABORT   = abort_q;
    assign TX_OVERRUN = overrun_q;

endmodule

// File: tb/tb_spi_readback_tx.sv
// Bench for spi_readback_tx: a behavioural SPI master drives frames at
// SCK = CLK/10; expected words are queued when requests are issued and a
// monitor compares the captured master word on every TX_DONE pulse.
module tb_spi_readback_tx;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SPI_SCK = 1'b0;
    logic        SPI_CS_N = 1'b1;
    logic        SPI_MISO;
    logic        RD_REQ = 1'b0;
    logic [7:0]  RD_ADDR = 8'h00;
    logic [31:0] MODE_FPGA = 32'h0;
    logic [13:0] SUB_CONTRAST = 14'h0;
    logic [4:0]  MULT_CONTRAST = 5'h0;
    logic [13:0] BEATEN_PIX_LEVEL = 14'h0;
    logic [19:0] ALL_CNT = 20'h0;
    logic        TX_BUSY, TX_DONE, TX_ABORT, TX_OVERRUN;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_done = 0;
    int          n_abort = 0;
    int          n_ovr = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rx_sh = 16'h0;

    spi_readback_tx dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .SPI_SCK          (SPI_SCK),
        .SPI_CS_N         (SPI_CS_N),
        .SPI_MISO         (SPI_MISO),
        .RD_REQ           (RD_REQ),
        .RD_ADDR          (RD_ADDR),
        .MODE_FPGA        (MODE_FPGA),
        .SUB_CONTRAST     (SUB_CONTRAST),
        .MULT_CONTRAST    (MULT_CONTRAST),
        .BEATEN_PIX_LEVEL (BEATEN_PIX_LEVEL),
        .ALL_CNT          (ALL_CNT),
        .TX_BUSY          (TX_BUSY),
        .TX_DONE          (TX_DONE),
        .TX_ABORT         (TX_ABORT),
        .TX_OVERRUN       (TX_OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Master samples MISO on SCK rise (mode 0).
    always @(posedge SPI_SCK) begin
        if (!SPI_CS_N) rx_sh <= {rx_sh[14:0], SPI_MISO};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard on each TX_DONE and counts event pulses.
    initial begin
        logic [15:0] w;
        forever begin
            @(negedge CLK);
            if (TX_DONE === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got word %h expected no frame", rx_sh);
                end else begin
                    w = exp_q.pop_front();
                    chk("frame_word", 32'(rx_sh), 32'(w));
                end
            end
            if (TX_ABORT === 1'b1)   n_abort++;
            if (TX_OVERRUN === 1'b1) n_ovr++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic req(input logic [7:0] addr);
        RD_REQ  = 1'b1;
        RD_ADDR = addr;
        @(negedge CLK);
        RD_REQ  = 1'b0;
    endtask

    // nbits SCK cycles; optional CS_N rise together with the last fall;
    // optional read request while SCK is high during bit req_bit.
    task automatic frame(input int nbits, input bit simul_end, input int req_bit,
                         input logic [7:0] req_addr);
        SPI_CS_N = 1'b0;
        wait_clk(5);
        for (int i = 0; i < nbits; i++) begin
            SPI_SCK = 1'b1;
            if (i == req_bit) begin
                req(req_addr);
                wait_clk(4);
            end else begin
                wait_clk(5);
            end
            SPI_SCK = 1'b0;
            if (simul_end && i == nbits - 1) SPI_CS_N = 1'b1;
            wait_clk(5);
        end
        SPI_CS_N = 1'b1;
        wait_clk(10);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_miso"},    32'(SPI_MISO),   32'd0);
        chk({tag, "_busy"},    32'(TX_BUSY),    32'd0);
        chk({tag, "_done"},    32'(TX_DONE),    32'd0);
        chk({tag, "_abort"},   32'(TX_ABORT),   32'd0);
        chk({tag, "_overrun"}, 32'(TX_OVERRUN), 32'd0);
    endtask

    initial begin
        logic [7:0]  t_addr[3] = '{8'h02, 8'h06, 8'h2A};
        logic [15:0] t_exp[3]  = '{16'h2ABC, 16'h000B, 16'h0000};

        wait_clk(4);
        chk_outputs_zero("reset");
        RESET = 1'b0;
        wait_clk(3);

        // ID word, basic frame
        req(8'h07);
        exp_q.push_back(16'hA55A);
        chk("busy_after_req", 32'(TX_BUSY), 32'd1);
        chk("miso_bit15_armed", 32'(SPI_MISO), 32'd1);
        frame(16, 1'b0, -1, 8'h00);
        chk("busy_after_frame", 32'(TX_BUSY), 32'd0);
        chk("done_count_1", 32'(n_done), 32'd1);

        // Snapshot held despite later input change
        MODE_FPGA = 32'h0000_0D01;
        wait_clk(1);
        req(8'h00);
        exp_q.push_back(16'h0D01);
        MODE_FPGA = 32'hFFFF_FFFF;
        wait_clk(3);
        frame(16, 1'b0, -1, 8'h00);

        // Abort after 7 falls, then unarmed frame returns zeros
        BEATEN_PIX_LEVEL = 14'h1234;
        req(8'h04);
        frame(7, 1'b0, -1, 8'h00);
        chk("abort_count", 32'(n_abort), 32'd1);
        chk("busy_after_abort", 32'(TX_BUSY), 32'd0);
        frame(16, 1'b0, -1, 8'h00);
        chk("unarmed_frame_word", 32'(rx_sh), 32'd0);
        chk("done_count_after_abort", 32'(n_done), 32'd2);

        // Re-request in ARMED, then overrun mid-shift
        ALL_CNT       = 20'hB_CAFE;
        MULT_CONTRAST = 5'h15;
        SUB_CONTRAST  = 14'h2ABC;
        req(8'h03);
        req(8'h05);
        exp_q.push_back(16'hCAFE);
        wait_clk(2);
        chk("no_overrun_in_armed", 32'(n_ovr), 32'd0);
        chk("miso_newest_word", 32'(SPI_MISO), 32'd1);
        frame(16, 1'b0, 8, 8'h07);
        chk("overrun_count", 32'(n_ovr), 32'd1);
        chk("busy_after_overrun_frame", 32'(TX_BUSY), 32'd0);

        // Table of further addresses including an unmapped index
        for (int k = 0; k < 3; k++) begin
            req(t_addr[k]);
            exp_q.push_back(t_exp[k]);
            frame(16, 1'b0, -1, 8'h00);
        end

        // CS_N rise coincident with 16th SCK fall: done only
        MODE_FPGA = 32'h9C3E_0000;
        req(8'h01);
        exp_q.push_back(16'h9C3E);
        frame(16, 1'b1, -1, 8'h00);
        chk("simul_abort_count", 32'(n_abort), 32'd1);
        chk("simul_done_count", 32'(n_done), 32'd7);

        // Reset mid-shift at bit 9
        req(8'h07);
        SPI_CS_N = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 9; i++) begin
            SPI_SCK = 1'b1;
            wait_clk(5);
            SPI_SCK = 1'b0;
            wait_clk(5);
        end
        chk("miso_before_reset", 32'(SPI_MISO), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        chk_outputs_zero("midreset");
        RESET = 1'b0;
        wait_clk(3);
        SPI_CS_N = 1'b1;
        wait_clk(10);
        chk("reset_no_abort", 32'(n_abort), 32'd1);
        chk("reset_no_done", 32'(n_done), 32'd7);
        req(8'h07);
        exp_q.push_back(16'hA55A);
        frame(16, 1'b0, -1, 8'h00);
        chk("final_done_count", 32'(n_done), 32'd8);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_readback_tx.md
# spi_readback_tx

SPI-slave transmit path for status readback: on a read request from the command decoder it snapshots one 16-bit status word and shifts it out MSB-first on MISO during the next chip-select frame. It sits beside the SPI receive path. It takes its values from the mode, contrast, beaten-pixel and frame-counter outputs of the control block, and replaces the tied-off SPI_DATA_OUT path. Everything runs on CLK; SCK and CS_N are oversampled.

## Interface
- SPI_W, 16, transmit word width (equals `SPI_WIDHT)
- SYNC_STAGES, 2, synchroniser depth for SCK and CS_N
- ID_WORD, 16'hA55A, constant returned at address 0x07
- CLK  in  1  system clock; must be at least 8× SCK
- RESET  in  1  synchronous, active-high reset
- SPI_SCK  in  1  SPI clock from master (async, mode 0)
- SPI_CS_N  in  1  SPI chip select, active low (async)
- SPI_MISO  out  1  serial data to master
- RD_REQ  in  1  one-CLK strobe: read command decoded
- RD_ADDR  in  8  register index (data byte of read command 'hC0)
- MODE_FPGA  in  32  working mode word
- SUB_CONTRAST  in  14  contrast offset
- MULT_CONTRAST  in  5  contrast gain
- BEATEN_PIX_LEVEL  in  14  beaten-pixel threshold
- ALL_CNT  in  20  frame/pixel counter
- TX_BUSY  out  1  high in ARMED or SHIFT
- TX_DONE  out  1  one-CLK pulse: 16 bits sent
- TX_ABORT  out  1  one-CLK pulse: CS_N rose before 16 bits
- TX_OVERRUN  out  1  one-CLK pulse: RD_REQ dropped while in SHIFT

## Operation
- Address map (snapshot word):
  - 0x00: MODE[15:0]
  - 0x01: MODE[31:16]
  - 0x02: {2'b0, SUB_CONTRAST}
  - 0x03: {11'b0, MULT_CONTRAST}
  - 0x04: {2'b0, BEATEN_PIX_LEVEL}
  - 0x05: ALL_CNT[15:0]
  - 0x06: {12'b0, ALL_CNT[19:16]}
  - 0x07: ID_WORD
  - any other index: 16'h0000
- Snapshot is taken on the CLK edge where RD_REQ is sampled. Later input changes do not affect the word.
- FSM states:
  - IDLE: MISO=0. RD_REQ → latch word into shreg, bitcnt=0, go to ARMED. CS_N fall → ignored; MISO stays 0 for the whole frame.
  - ARMED: MISO=shreg[15]. RD_REQ → re-latch, newest wins, no overrun. CS_N fall → SHIFT.
  - SHIFT: MISO=shreg[15]. Each detected SCK fall → shreg shifts left (0 in), bitcnt++.
    - bitcnt reaches 15 and another SCK fall is detected (16th fall) → DONE.
    - CS_N rise with bitcnt < 16 → TX_ABORT, go to IDLE.
    - RD_REQ → TX_OVERRUN pulse, request discarded.
  - DONE: one cycle. TX_DONE=1, MISO=0, go to IDLE. An RD_REQ in this cycle is honoured: latch, then ARMED.
- Simultaneous CS_N rise and 16th SCK fall in the same CLK: DONE wins, no abort.
- CS_N rise in ARMED: no effect (frame never started).
- SCK edges while CS_N high: ignored.
- RESET in any state → IDLE, shreg=0, bitcnt=0. Any frame in progress is abandoned with no pulse.

## Timing
- Reset values: SPI_MISO=0, TX_BUSY=0, TX_DONE=0, TX_ABORT=0, TX_OVERRUN=0.
- Synchroniser plus edge detect: pin edge to internal event = SYNC_STAGES+1 CLK (3 at default).
- MISO updates 1 CLK after the detected SCK fall, which is 4 CLK after the pin edge.
- With CLK ≥ 8×SCK, MISO settles before the next SCK rise.
- Bit 15 is valid on MISO from the ARMED entry cycle, i.e. before the first SCK rise.
- TX_BUSY rises 1 CLK after RD_REQ and falls in the DONE/abort cycle.
- All status outputs are registered.

## Structure
- Shared constants in define.v: `SPI_WIDHT`, `CMD_READ ('hC0)`, the register-index constants 0x00–0x07, and `ID_WORD`.
- FSM state encoding stays local to the module.
- Sub-module spi_sync_edge: SYNC_STAGES-flop synchroniser with rise/fall pulse outputs; instantiated for SCK and for CS_N.
- Address mux, shift register, counter and FSM stay in spi_readback_tx (about 200 lines).

## Test plan
- Reset, RD_REQ with addr 0x07, full 16-bit frame at SCK=CLK/10 → master samples 16'hA55A; one TX_DONE pulse; TX_BUSY low afterwards.
- MODE_FPGA=32'h0000_0D01, RD_REQ addr 0x00, then change MODE_FPGA before the frame → master still reads 16'h0D01.
- RD_REQ addr 0x04, CS_N rises after 7 SCK falls → TX_ABORT pulses; state is IDLE; next frame without a request reads all zeros.
- RD_REQ in ARMED with addr 0x05 replacing 0x03 → ALL_CNT[15:0] returned, no TX_OVERRUN. RD_REQ mid-SHIFT → TX_OVERRUN pulse; current word is unchanged.
- Unmapped addr 0x2A → 16'h0000. CS_N rise and 16th SCK fall arriving on the same CLK → TX_DONE only.
- RESET asserted mid-SHIFT at bit 9 → all outputs 0 next cycle; no DONE/ABORT pulse; a subsequent request and frame work normally.
